operand_triplet_loader: RTL and testbench

- Upstream feeder for the three-operand compute stage, which consumes `a`, `b` and `c` in parallel.
- Accepts a byte stream with a valid/ready handshake and frame marker, and groups consecutive bytes into (a,b,c) triplets.
- Presents each triplet on a registered valid/ready output.
- Pads short frame tails and counts how many partial triplets it has emitted.

---
 rtl/operand_triplet_loader_pkg.sv | 24 ++
 rtl/operand_triplet_loader_out_reg.sv | 79 +++++++
 rtl/operand_triplet_loader.sv | 166 ++++++++++++++++
 tb/tb_operand_triplet_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/operand_triplet_loader_pkg.sv
// Shared types and defaults for the operand triplet loader.
//   state_e   : loader FSM states (COLLECT gathers bytes, FULL holds a
//               completed triplet until the output register frees up).
//   triplet_t : one (a,b,c) operand group plus its partial/last flags,
//               at the default operand width.
package operand_triplet_loader_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam logic [DEF_DATA_W-1:0] DEF_PAD_VALUE = 8'h00;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_DATA_W-1:0] c;
    logic                  partial;
    logic                  last;
  } triplet_t;

endpackage

// File: rtl/operand_triplet_loader_out_reg.sv
// triplet_out_reg: registered valid/ready output stage for one triplet.
//   clk, rst_n      : clock, async active-low reset
//   load            : capture load_* this cycle (caller only asserts it
//                     when the register is empty or being consumed)
//   load_a/b/c      : operand values to capture
//   load_partial    : captured triplet has padded slots
//   load_last       : captured triplet closes its frame
//   out_ready       : downstream accepts the held triplet
//   out_a/b/c, out_valid, out_partial, out_last : registered outputs
module triplet_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_a,
  input  logic [DATA_W-1:0] load_b,
  input  logic [DATA_W-1:0] load_c,
  input  logic              load_partial,
  input  logic              load_last,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic              out_valid,
  output logic              out_partial,
  output logic              out_last
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic              valid_q, valid_d;
  logic              partial_q, partial_d;
  logic              last_q, last_d;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    partial_d = partial_q;
    last_d    = last_q;
    valid_d   = valid_q;
    if (load) begin
      a_d       = load_a;
      b_d       = load_b;
      c_d       = load_c;
      partial_d = load_partial;
      last_d    = load_last;
      valid_d   = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      partial_q <= 1'b0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      partial_q <= partial_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
    end
  end

  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_c       = c_q;
  assign out_valid   = valid_q;
  assign out_partial = partial_q;
  assign out_last    = last_q;

endmodule

// File: rtl/operand_triplet_loader.sv
// operand_triplet_loader: groups a valid/ready byte stream into (a,b,c)
// triplets for the three-operand compute stage. Frames ending mid-triplet
// are padded with PAD_VALUE and flagged partial; partial_cnt counts
// partial triplets handed downstream (saturating).
//   clk, rst_n                  : clock, async active-low reset
//   in_data/in_valid/in_last    : input byte stream, in_ready back-pressure
//   out_a/out_b/out_c/out_valid : registered triplet, out_ready from consumer
//   out_partial, out_last       : triplet padded / closes its frame
//   partial_cnt                 : partial triplets emitted since reset
module operand_triplet_loader
  import operand_triplet_loader_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] PAD_VALUE = DATA_W'(DEF_PAD_VALUE),
  parameter int unsigned       CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_partial,
  output logic              out_last,
  output logic [CNT_W-1:0]  partial_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] col_a_q, col_a_d, col_b_q, col_b_d, col_c_q, col_c_d;
  logic              col_partial_q, col_partial_d;
  logic              col_last_q, col_last_d;
  logic [CNT_W-1:0]  partial_cnt_q, partial_cnt_d;

  logic              accept, complete, out_free;
  logic [DATA_W-1:0] m_a, m_b, m_c;
  logic              m_partial;

  logic              load;
  logic [DATA_W-1:0] load_a, load_b, load_c;
  logic              load_partial, load_last;

  assign in_ready = (state_q == COLLECT);
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((idx_q == 2'd2) || in_last);
  assign out_free = !out_valid || out_ready;

  // Triplet as it would look if the current byte completes it: the byte
  // lands in slot idx, earlier slots come from the collection regs and
  // later slots are padding.
  always_comb begin
    m_a       = (idx_q == 2'd0) ? in_data : col_a_q;
    m_b       = (idx_q == 2'd1) ? in_data :
                (idx_q == 2'd2) ? col_b_q : PAD_VALUE;
    m_c       = (idx_q == 2'd2) ? in_data : PAD_VALUE;
    m_partial = (idx_q != 2'd2);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    col_a_d       = col_a_q;
    col_b_d       = col_b_q;
    col_c_d       = col_c_q;
    col_partial_d = col_partial_q;
    col_last_d    = col_last_q;
    load          = 1'b0;
    load_a        = col_a_q;
    load_b        = col_b_q;
    load_c        = col_c_q;
    load_partial  = col_partial_q;
    load_last     = col_last_q;

    unique case (state_q)
      COLLECT: begin
        if (complete) begin
          idx_d = 2'd0;
          if (out_free) begin
            // Bypass the collection regs so the triplet appears one
            // cycle after its completing byte.
            load         = 1'b1;
            load_a       = m_a;
            load_b       = m_b;
            load_c       = m_c;
            load_partial = m_partial;
            load_last    = in_last;
          end else begin
            col_a_d       = m_a;
            col_b_d       = m_b;
            col_c_d       = m_c;
            col_partial_d = m_partial;
            col_last_d    = in_last;
            state_d       = FULL;
          end
        end else if (accept) begin
          if (idx_q == 2'd0) col_a_d = in_data;
          else               col_b_d = in_data;
          idx_d = idx_q + 2'd1;
        end
      end
      FULL: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    partial_cnt_d = partial_cnt_q;
    if (out_valid && out_ready && out_partial && (partial_cnt_q != '1))
      partial_cnt_d = partial_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      idx_q         <= '0;
      col_a_q       <= '0;
      col_b_q       <= '0;
      col_c_q       <= '0;
      col_partial_q <= 1'b0;
      col_last_q    <= 1'b0;
      partial_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      col_a_q       <= col_a_d;
      col_b_q       <= col_b_d;
      col_c_q       <= col_c_d;
      col_partial_q <= col_partial_d;
      col_last_q    <= col_last_d;
      partial_cnt_q <= partial_cnt_d;
    end
  end

  assign partial_cnt = partial_cnt_q;

  triplet_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_a       (load_a),
    .load_b       (load_b),
    .load_c       (load_c),
    .load_partial (load_partial),
    .load_last    (load_last),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_c        (out_c),
    .out_valid    (out_valid),
    .out_partial  (out_partial),
    .out_last     (out_last)
  );

endmodule

// File: tb/tb_operand_triplet_loader.sv
// Directed bench for operand_triplet_loader. A second instance with a
// 2-bit counter shares all inputs and is checked for counter saturation.
module tb_operand_triplet_loader;
  import operand_triplet_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_partial, out_last;
  logic [7:0] out_a, out_b, out_c, partial_cnt;
  logic       s_in_ready, s_out_valid, s_out_partial, s_out_last;
  logic [7:0] s_out_a, s_out_b, s_out_c;
  logic [1:0] s_partial_cnt;
  triplet_t   obs;
  int         total = 0;
  int         bad = 0;

  assign obs = {out_a, out_b, out_c, out_partial, out_last};

  always #5 clk = ~clk;

  operand_triplet_loader #(.DATA_W(8), .PAD_VALUE(8'h00), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_partial(out_partial), .out_last(out_last), .partial_cnt(partial_cnt));

  operand_triplet_loader #(.DATA_W(8), .PAD_VALUE(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(s_in_ready), .out_a(s_out_a), .out_b(s_out_b),
    .out_c(s_out_c), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_partial(s_out_partial), .out_last(s_out_last), .partial_cnt(s_partial_cnt));

  function automatic triplet_t mk(input logic [7:0] a, b, c, input logic p, l);
    mk = '{a: a, b: b, c: c, partial: p, last: l};
  endfunction

  // Called at a falling edge: apply inputs, let one rising edge pass,
  // return at the next falling edge where outputs are sampled.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (obs !== mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0)) begin bad++; $display("FAIL reset_out got=%h exp=%h", obs, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0)); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (partial_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", partial_cnt); end
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [7:0] bytes [6];
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, bytes[i], (i == 5), 1'b1);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      total++; if (out_valid !== (i == 2 || i == 5)) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, (i == 2 || i == 5)); end
      if (i == 2) begin
        total++; if (obs !== mk(8'h01, 8'h02, 8'h03, 1'b0, 1'b0)) begin bad++; $display("FAIL stream_t1 got=%h exp=%h", obs, mk(8'h01, 8'h02, 8'h03, 1'b0, 1'b0)); end
      end
      if (i == 5) begin
        total++; if (obs !== mk(8'h04, 8'h05, 8'h06, 1'b0, 1'b1)) begin bad++; $display("FAIL stream_t2 got=%h exp=%h", obs, mk(8'h04, 8'h05, 8'h06, 1'b0, 1'b1)); end
      end
    end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_short_tail();
    step(1'b1, 8'h0A, 1'b0, 1'b1);
    step(1'b1, 8'h0B, 1'b1, 1'b1);
    total++; if (obs !== mk(8'h0A, 8'h0B, 8'h00, 1'b1, 1'b1)) begin bad++; $display("FAIL tail2 got=%h exp=%h", obs, mk(8'h0A, 8'h0B, 8'h00, 1'b1, 1'b1)); end
    total++; if (partial_cnt !== 8'd0) begin bad++; $display("FAIL tail2_cnt_pre got=%0d exp=0", partial_cnt); end
    idle(1'b1);
    total++; if (partial_cnt !== 8'd1) begin bad++; $display("FAIL tail2_cnt got=%0d exp=1", partial_cnt); end
    step(1'b1, 8'h0C, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || obs !== mk(8'h0C, 8'h00, 8'h00, 1'b1, 1'b1)) begin bad++; $display("FAIL tail1 got=%b/%h exp=1/%h", out_valid, obs, mk(8'h0C, 8'h00, 8'h00, 1'b1, 1'b1)); end
    idle(1'b1);
    total++; if (partial_cnt !== 8'd2) begin bad++; $display("FAIL tail1_cnt got=%0d exp=2", partial_cnt); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h11 + 8'(i), (i == 5), 1'b0);
      if (i >= 2) begin
        total++; if (out_valid !== 1'b1 || obs !== mk(8'h11, 8'h12, 8'h13, 1'b0, 1'b0)) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, out_valid, obs, mk(8'h11, 8'h12, 8'h13, 1'b0, 1'b0)); end
      end
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    // Upstream offers a byte while stalled; it must not be taken.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0 || obs !== mk(8'h11, 8'h12, 8'h13, 1'b0, 1'b0)) begin bad++; $display("FAIL bp_stall got=%b/%h exp=0/%h", in_ready, obs, mk(8'h11, 8'h12, 8'h13, 1'b0, 1'b0)); end
    idle(1'b1);
    total++; if (out_valid !== 1'b1 || obs !== mk(8'h14, 8'h15, 8'h16, 1'b0, 1'b1)) begin bad++; $display("FAIL bp_release got=%b/%h exp=1/%h", out_valid, obs, mk(8'h14, 8'h15, 8'h16, 1'b0, 1'b1)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
    idle(1'b1);
    total++; if (out_valid !== 1'b0 || partial_cnt !== 8'd2) begin bad++; $display("FAIL bp_drain got=%b/%0d exp=0/2", out_valid, partial_cnt); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 8'h31, 1'b0, 1'b1);
    step(1'b1, 8'h32, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h35, 1'b0, 1'b0);
    total++; if (obs !== mk(8'h31, 8'h32, 8'h33, 1'b0, 1'b0)) begin bad++; $display("FAIL sim_pre got=%h exp=%h", obs, mk(8'h31, 8'h32, 8'h33, 1'b0, 1'b0)); end
    step(1'b1, 8'h36, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || obs !== mk(8'h34, 8'h35, 8'h36, 1'b0, 1'b1)) begin bad++; $display("FAIL sim_load got=%b/%h exp=1/%h", out_valid, obs, mk(8'h34, 8'h35, 8'h36, 1'b0, 1'b1)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sim_no_full got=%b exp=1", in_ready); end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || obs !== mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0) || partial_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_async got=%b/%h/%0d exp=0/%h/0", out_valid, obs, partial_cnt, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0)); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h21, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h23, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || obs !== mk(8'h21, 8'h22, 8'h23, 1'b0, 1'b0)) begin bad++; $display("FAIL rst_mid_after got=%b/%h exp=1/%h", out_valid, obs, mk(8'h21, 8'h22, 8'h23, 1'b0, 1'b0)); end
    idle(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_full_pre got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0)) begin bad++; $display("FAIL rst_full_async got=%b/%b/%h exp=1/0/%h", in_ready, out_valid, obs, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0)); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h21, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h23, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || obs !== mk(8'h21, 8'h22, 8'h23, 1'b0, 1'b0)) begin bad++; $display("FAIL rst_full_after got=%b/%h exp=1/%h", out_valid, obs, mk(8'h21, 8'h22, 8'h23, 1'b0, 1'b0)); end
    idle(1'b1);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    total++; if (s_partial_cnt !== 2'd0) begin bad++; $display("FAIL sat_start got=%0d exp=0", s_partial_cnt); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h60 + 8'(i), 1'b1, 1'b1);
      idle(1'b1);
      total++; if (s_partial_cnt !== exp_sat[i]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, s_partial_cnt, exp_sat[i]); end
      total++; if (partial_cnt !== 8'(i + 1)) begin bad++; $display("FAIL sat_wide_cnt[%0d] got=%0d exp=%0d", i, partial_cnt, i + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_short_tail();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
